dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests issued by the core's MEM stage (alu_result_mem as address, write_data_memory_mem as store data, memread_mem/memwrite_mem as command). It owns a word-organised RAM with configurable wait states and returns load data sign- or zero-extended per funct3. It asserts a stall toward the hazard logic while an access is in flight, so the EX/MEM and MEM/WB registers hold until the response is presented.

---
 rtl/dmem_responder.sv | 86 ++++++++
 tb/tb_dmem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word RAM serving MEM-stage loads/stores with a pipeline stall
module dmem_responder #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        stall_o,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic a_write;
  logic [31:0] a_addr, a_wdata;
  logic [2:0] a_f3;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] word, rdata, wd;
  logic [15:0] half;
  logic [7:0] byt;
  logic [3:0] be;
  logic misal, illegal, err;
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? (WAIT_CYCLES > 0 ? WAIT : ACCESS) : IDLE)
             : state == WAIT ? (cnt == 4'd0 ? ACCESS : WAIT)
             : state == ACCESS ? RESP : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    stall_o = (state == IDLE && req_valid) || state == WAIT || state == ACCESS;
  end
  always_comb begin
    idx = a_addr[AW+1:2];
    word = mem[idx];
    byt = word[{a_addr[1:0], 3'b000} +: 8];
    half = a_addr[1] ? word[31:16] : word[15:0];
    rdata = a_f3[1:0] == 2'b00 ? {{24{~a_f3[2] & byt[7]}}, byt}
          : a_f3[1:0] == 2'b01 ? {{16{~a_f3[2] & half[15]}}, half} : word;
    misal = (a_f3[1:0] == 2'b01 && a_addr[0]) || (a_f3[1:0] == 2'b10 && |a_addr[1:0]);
    illegal = a_write ? (a_f3[2] || &a_f3[1:0]) : (&a_f3[1:0] || &a_f3[2:1]);
    err = |a_addr[31:AW+2] || misal || illegal;
    be = a_f3[1:0] == 2'b00 ? 4'b0001 << a_addr[1:0]
       : a_f3[1:0] == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = a_f3[1:0] == 2'b00 ? {4{a_wdata[7:0]}}
       : a_f3[1:0] == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_write <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
      a_f3 <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        a_write <= req_write;
        a_addr <= req_addr;
        a_wdata <= req_wdata;
        a_f3 <= req_funct3;
        cnt <= CNT_INIT;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == ACCESS) begin
        resp_rdata <= (err || a_write) ? '0 : rdata;
        resp_err <= err;
      end
    end
  always_ff @(posedge clk)
    if (state == ACCESS && a_write && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + random load/store checks of dmem_responder (2 and 0 wait states) against a byte-array model
module tb_dmem_responder;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic req_valid, req_write, req_ready, stall_o, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0] req_funct3;
  logic req_valid0, req_write0, req_ready0, stall0, resp_valid0, resp_err0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0;
  logic [2:0] req_funct30;
  int vectors = 0, miscompares = 0;
  logic [7:0] mb [2][4096];
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(req_ready), .stall_o(stall_o), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err));
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
    .req_ready(req_ready0), .stall_o(stall0), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void ref_op(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f, output bit e, output logic [31:0] r);
    int sz = 1 << f[1:0];
    bit bad = w ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    e = bad || a >= 32'h1000 || (a % sz) != 0;
    r = '0;
    if (e) return;
    if (w) for (int i = 0; i < sz; i++) mb[m][a + i] = d[8*i +: 8];
    else begin
      for (int i = 0; i < sz; i++) r[8*i +: 8] = mb[m][a + i];
      if (!f[2] && sz < 4 && r[8*sz-1]) r |= ~((32'd1 << (8*sz)) - 1);
    end
  endfunction
  task automatic op2(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     output logic [31:0] got);
    bit e;
    logic [31:0] r;
    ref_op(0, w, a, d, f, e, r);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
    #1;
    chk("accept_ready", req_ready, 1);
    chk("accept_stall", stall_o, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("resp_valid_k%0d", k), resp_valid, 32'(k == 4));
      chk($sformatf("stall_k%0d", k), stall_o, 32'(k < 4));
      chk($sformatf("ready_k%0d", k), req_ready, 0);
    end
    chk($sformatf("rdata_%h_f%0d", a, f), resp_rdata, r);
    chk($sformatf("err_%h_f%0d", a, f), resp_err, 32'(e));
    got = resp_rdata;
    @(negedge clk);
    chk("idle_valid", resp_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("hold_rdata", resp_rdata, r);
  endtask
  task automatic op0(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bit e;
    logic [31:0] r;
    ref_op(1, w, a, d, f, e, r);
    req_valid0 = 1'b1; req_write0 = w; req_addr0 = a; req_wdata0 = d; req_funct30 = f;
    #1;
    chk("b2b_ready_idle", req_ready0, 1);
    chk("b2b_stall_idle", stall0, 1);
    @(posedge clk);
    #1;
    req_write0 = ~w; req_addr0 = $urandom; req_wdata0 = $urandom; req_funct30 = 3'($urandom);
    @(negedge clk);
    chk("b2b_ready_access", req_ready0, 0);
    chk("b2b_stall_access", stall0, 1);
    chk("b2b_valid_access", resp_valid0, 0);
    @(negedge clk);
    chk("b2b_valid_resp", resp_valid0, 1);
    chk("b2b_ready_resp", req_ready0, 0);
    chk("b2b_stall_resp", stall0, 0);
    chk($sformatf("b2b_rdata_%h_f%0d", a, f), resp_rdata0, r);
    chk($sformatf("b2b_err_%h_f%0d", a, f), resp_err0, 32'(e));
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] got, a;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_funct30 = 0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_ready0", req_ready0, 1);
    chk("rst_valid0", resp_valid0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op2(1, 32'h10, 32'hDEADBEEF, 3'b010, got);
    op2(0, 32'h10, 32'h0, 3'b010, got);  chk("lw_10", got, 32'hDEADBEEF);
    op2(0, 32'h13, 32'h0, 3'b000, got);  chk("lb_13", got, 32'hFFFFFFDE);
    op2(0, 32'h13, 32'h0, 3'b100, got);  chk("lbu_13", got, 32'h000000DE);
    op2(0, 32'h12, 32'h0, 3'b001, got);  chk("lh_12", got, 32'hFFFFDEAD);
    op2(0, 32'h10, 32'h0, 3'b101, got);  chk("lhu_10", got, 32'h0000BEEF);
    op2(1, 32'h11, 32'h55, 3'b000, got);
    op2(0, 32'h10, 32'h0, 3'b010, got);  chk("lw_after_sb", got, 32'hDEAD55EF);
    op2(1, 32'h12, 32'h1234, 3'b001, got);
    op2(0, 32'h10, 32'h0, 3'b010, got);  chk("lw_after_sh", got, 32'h123455EF);
    op2(0, 32'h12, 32'h0, 3'b010, got);  chk("err_lw_mis", resp_err, 1);
    op2(0, 32'h11, 32'h0, 3'b001, got);  chk("err_lh_mis", resp_err, 1);
    op2(0, 32'h1000, 32'h0, 3'b010, got); chk("err_lw_oob", resp_err, 1);
    op2(0, 32'h10, 32'h0, 3'b011, got);  chk("err_f011", resp_err, 1);
    op2(1, 32'h0, 32'h11223344, 3'b010, got);
    op2(1, 32'h1000, 32'hCAFEF00D, 3'b010, got); chk("err_sw_oob", resp_err, 1);
    op2(0, 32'h0, 32'h0, 3'b010, got);   chk("lw_0_unchanged", got, 32'h11223344);
    op2(1, 32'h20, 32'h0, 3'b010, got);
    op2(0, 32'h10, 32'h0, 3'b010, got);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_stall", stall_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", req_ready, 1);
    chk("async_rst_stall", stall_o, 0);
    chk("async_rst_valid", resp_valid, 0);
    chk("async_rst_rdata", resp_rdata, 0);
    chk("async_rst_err", resp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op2(0, 32'h20, 32'h0, 3'b010, got);  chk("lw_20_cancelled", got, 32'h0);
    for (int i = 0; i < 16; i++) op2(1, 32'(4*i), $urandom, 3'b010, got);
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 63) : 32'($urandom_range(0, 63));
      op2(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), got);
    end
    for (int i = 0; i < 16; i++) op0(1, 32'(4*i), $urandom, 3'b010);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 63) : 32'($urandom_range(0, 63));
      op0(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
    end
    req_valid0 = 1'b0;
    #1;
    chk("b2b_end_stall", stall0, 0);
    chk("b2b_end_ready", req_ready0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
